// File: rtl/pcie_perst_link_monitor.sv
// PCIe endpoint PERST#/link bring-up monitor.
// Synchronises board PERST#, sequences the user-logic reset release, then tracks
// link training through debounce to a stable link-up, flagging timeouts and
// counting link-down events.
module pcie_perst_link_monitor #(
  parameter int unsigned SYNC_STAGES  = 3,       // 2..4
  parameter int unsigned REL_DELAY    = 64,      // >= 2
  parameter int unsigned LINK_TIMEOUT = 200000,
  parameter int unsigned DEBOUNCE     = 16,      // >= 2
  parameter logic [5:0]  LTSSM_L0     = 6'h10
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       perst_n_in,
  input  logic       user_lnk_up,
  input  logic [5:0] ltssm_state,
  output logic       user_reset,
  output logic       perst_n_sync,
  output logic       link_up_stable,
  output logic       link_timeout,
  output logic [7:0] link_down_cnt,
  output logic [2:0] mon_state
);

  localparam int unsigned RelW = $clog2(REL_DELAY) + 1;
  localparam int unsigned TmoW = $clog2(LINK_TIMEOUT) + 1;
  localparam int unsigned DebW = $clog2(DEBOUNCE) + 1;

  localparam logic [RelW-1:0] RelLast = RelW'(REL_DELAY - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(LINK_TIMEOUT - 1);
  localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPerst    = 3'd1,
    StWaitRel  = 3'd2,
    StWaitLink = 3'd3,
    StDebounce = 3'd4,
    StActive   = 3'd5,
    StTimeout  = 3'd6
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [RelW-1:0]        rel_cnt_q;
  logic [TmoW-1:0]        tmo_cnt_q;
  logic [DebW-1:0]        deb_cnt_q;
  logic                   user_reset_q;
  logic                   link_up_stable_q;
  logic                   link_timeout_q;
  logic [7:0]             link_down_cnt_q;
  logic                   link_ok;

  assign link_ok = user_lnk_up && (ltssm_state == LTSSM_L0);

  // PERST# synchroniser shift chain; the last stage is the qualified PERST#.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], perst_n_in};
    end
  end

  // Bring-up FSM with registered status outputs.
  // The cycle on which a qualifying condition is first observed counts as the
  // first cycle of the delay/debounce window, so the window lengths are exact.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q          <= StIdle;
      rel_cnt_q        <= '0;
      tmo_cnt_q        <= '0;
      deb_cnt_q        <= '0;
      user_reset_q     <= 1'b1;
      link_up_stable_q <= 1'b0;
      link_timeout_q   <= 1'b0;
      link_down_cnt_q  <= '0;
    end else if (!sync_q[SYNC_STAGES-1]) begin
      // PERST# asserted: back to PERST from anywhere; sticky status survives.
      state_q          <= StPerst;
      rel_cnt_q        <= '0;
      tmo_cnt_q        <= '0;
      deb_cnt_q        <= '0;
      user_reset_q     <= 1'b1;
      link_up_stable_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q <= StPerst;
        end
        StPerst: begin
          rel_cnt_q <= RelW'(1);
          state_q   <= StWaitRel;
        end
        StWaitRel: begin
          if (rel_cnt_q >= RelLast) begin
            user_reset_q <= 1'b0;
            tmo_cnt_q    <= '0;
            state_q      <= StWaitLink;
          end else begin
            rel_cnt_q <= rel_cnt_q + 1'b1;
          end
        end
        StWaitLink: begin
          // Link-up takes priority over a coincident timeout.
          if (link_ok) begin
            deb_cnt_q <= DebW'(1);
            state_q   <= StDebounce;
          end else if (tmo_cnt_q >= TmoLast) begin
            link_timeout_q <= 1'b1;
            state_q        <= StTimeout;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        StDebounce: begin
          // Timeout counter is deliberately left untouched on a drop.
          if (!link_ok) begin
            deb_cnt_q <= '0;
            state_q   <= StWaitLink;
          end else if (deb_cnt_q >= DebLast) begin
            link_up_stable_q <= 1'b1;
            state_q          <= StActive;
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
        end
        StActive: begin
          // Only loss of link-up leaves ACTIVE; LTSSM excursions are ignored.
          if (!user_lnk_up) begin
            link_up_stable_q <= 1'b0;
            tmo_cnt_q        <= '0;
            if (link_down_cnt_q != 8'hFF) begin
              link_down_cnt_q <= link_down_cnt_q + 8'd1;
            end
            state_q <= StWaitLink;
          end
        end
        StTimeout: begin
          if (link_ok) begin
            deb_cnt_q <= DebW'(1);
            state_q   <= StDebounce;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign user_reset     = user_reset_q;
  assign perst_n_sync   = sync_q[SYNC_STAGES-1];
  assign link_up_stable = link_up_stable_q;
  assign link_timeout   = link_timeout_q;
  assign link_down_cnt  = link_down_cnt_q;
  assign mon_state      = state_q;

endmodule
